// File: rtl/rrf_freelist_ctrl.sv
// Rename register file free-list controller: head/tail pointers, free count, all-or-nothing grants.
// Optional build macro RRF_STALL_CNT_EN adds a saturating allocation-stall counter (stall_cnt_o).
module rrf_freelist_ctrl #(
    parameter int unsigned RRF_NUM = 64,
    parameter int unsigned RRF_SEL = 6
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               alloc_req1_i,
    input  logic               alloc_req2_i,
    output logic               alloc_ok_o,
    output logic               alloc_en1_o,
    output logic               alloc_en2_o,
    output logic [RRF_SEL-1:0] alloc_tag1_o,
    output logic [RRF_SEL-1:0] alloc_tag2_o,
    output logic [RRF_SEL-1:0] rrfptr_o,
    output logic               nextrrfcyc_o,
    input  logic [1:0]         commit_num_i,
    output logic [RRF_SEL-1:0] commit_ptr_o,
    output logic [RRF_SEL:0]   free_num_o,
    input  logic               flush_i
`ifdef RRF_STALL_CNT_EN
    ,
    output logic [31:0]        stall_cnt_o
`endif
);

    localparam logic [RRF_SEL:0] FreeAll = (RRF_SEL+1)'(RRF_NUM);

    logic [RRF_SEL-1:0] rrfptr_q, rrfptr_d;
    logic               nextrrfcyc_q, nextrrfcyc_d;
    logic [RRF_SEL-1:0] commit_ptr_q, commit_ptr_d;
    logic               comcyc_q, comcyc_d;
    logic [RRF_SEL:0]   free_num_q, free_num_d;

    logic [1:0]         need;
    logic [RRF_SEL:0]   need_ext, granted_ext, commit_ext;
    logic [RRF_SEL:0]   head_sum, tail_sum;

    always_comb begin
        need         = {1'b0, alloc_req1_i} + {1'b0, alloc_req2_i};
        need_ext     = {{(RRF_SEL-1){1'b0}}, need};
        commit_ext   = {{(RRF_SEL-1){1'b0}}, commit_num_i};
        alloc_ok_o   = reset_n_i & ~flush_i & (need_ext <= free_num_q);
        alloc_en1_o  = alloc_req1_i & alloc_ok_o;
        alloc_en2_o  = alloc_req2_i & alloc_ok_o;
        alloc_tag1_o = rrfptr_q;
        alloc_tag2_o = rrfptr_q + {{(RRF_SEL-1){1'b0}}, alloc_req1_i};
        granted_ext  = alloc_ok_o ? need_ext : '0;
        // Carry out of the extended sum marks a wrap past RRF_NUM-1.
        head_sum     = {1'b0, rrfptr_q} + granted_ext;
        tail_sum     = {1'b0, commit_ptr_q} + commit_ext;

        commit_ptr_d = tail_sum[RRF_SEL-1:0];
        comcyc_d     = comcyc_q ^ tail_sum[RRF_SEL];
        if (flush_i) begin
            rrfptr_d     = commit_ptr_d;
            nextrrfcyc_d = comcyc_d;
            free_num_d   = FreeAll;
        end else begin
            rrfptr_d     = head_sum[RRF_SEL-1:0];
            nextrrfcyc_d = nextrrfcyc_q ^ head_sum[RRF_SEL];
            free_num_d   = free_num_q - granted_ext + commit_ext;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            rrfptr_q     <= '0;
            nextrrfcyc_q <= 1'b0;
            commit_ptr_q <= '0;
            comcyc_q     <= 1'b0;
            free_num_q   <= FreeAll;
        end else begin
            rrfptr_q     <= rrfptr_d;
            nextrrfcyc_q <= nextrrfcyc_d;
            commit_ptr_q <= commit_ptr_d;
            comcyc_q     <= comcyc_d;
            free_num_q   <= free_num_d;
        end
    end

    assign rrfptr_o     = rrfptr_q;
    assign nextrrfcyc_o = nextrrfcyc_q;
    assign commit_ptr_o = commit_ptr_q;
    assign free_num_o   = free_num_q;

    // Retiring more entries than are in flight corrupts the free count.
    always_ff @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (commit_ext <= FreeAll - free_num_q)
            else $error("commit_num_i exceeds in-flight count");
        end
    end

`ifdef RRF_STALL_CNT_EN
    logic [31:0] stall_cnt_q;
    logic        stall_cond;

    assign stall_cond = reset_n_i & ~flush_i & (need != 2'd0) & ~alloc_ok_o;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            stall_cnt_q <= '0;
        end else if (stall_cond && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_rrf_freelist_ctrl.sv
// Scoreboard bench for rrf_freelist_ctrl: stimulus pushes expected per-cycle outputs, a negedge
// monitor pops and compares them. Covers the stall counter when RRF_STALL_CNT_EN is defined.
module tb_rrf_freelist_ctrl;

    logic       clk;
    logic       reset_n;
    logic       req1, req2;
    logic       ok, en1, en2;
    logic [5:0] tag1, tag2, rrfptr, commit_ptr;
    logic       nextrrfcyc;
    logic [1:0] commit_num;
    logic [6:0] free_num;
    logic       flush;
`ifdef RRF_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    rrf_freelist_ctrl #(
        .RRF_NUM(64),
        .RRF_SEL(6)
    ) dut (
        .clk_i       (clk),
        .reset_n_i   (reset_n),
        .alloc_req1_i(req1),
        .alloc_req2_i(req2),
        .alloc_ok_o  (ok),
        .alloc_en1_o (en1),
        .alloc_en2_o (en2),
        .alloc_tag1_o(tag1),
        .alloc_tag2_o(tag2),
        .rrfptr_o    (rrfptr),
        .nextrrfcyc_o(nextrrfcyc),
        .commit_num_i(commit_num),
        .commit_ptr_o(commit_ptr),
        .free_num_o  (free_num),
        .flush_i     (flush)
`ifdef RRF_STALL_CNT_EN
        ,
        .stall_cnt_o (stall_cnt)
`endif
    );

    typedef struct {
        logic        ok, en1, en2, cyc;
        logic [5:0]  tag1, tag2, ptr, cptr;
        logic [6:0]  free;
        logic [31:0] stall;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Bench-side state, advanced in integer arithmetic after every cycle.
    int m_ptr, m_cyc, m_cptr, m_ccyc, m_free, m_stall;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("alloc_ok", 32'(ok), 32'(e.ok));
            chk("alloc_en1", 32'(en1), 32'(e.en1));
            chk("alloc_en2", 32'(en2), 32'(e.en2));
            chk("alloc_tag1", 32'(tag1), 32'(e.tag1));
            chk("alloc_tag2", 32'(tag2), 32'(e.tag2));
            chk("rrfptr", 32'(rrfptr), 32'(e.ptr));
            chk("nextrrfcyc", 32'(nextrrfcyc), 32'(e.cyc));
            chk("commit_ptr", 32'(commit_ptr), 32'(e.cptr));
            chk("free_num", 32'(free_num), 32'(e.free));
`ifdef RRF_STALL_CNT_EN
            chk("stall_cnt", stall_cnt, e.stall);
`endif
        end
    end

    // One clock of stimulus; hok is the hand-computed grant expected this cycle.
    task automatic step(input logic r1, input logic r2, input logic [1:0] cn,
                        input logic fl, input logic rn, input logic hok);
        exp_t e;
        int   granted, np, nc;
        @(posedge clk);
        #1;
        req1       = r1;
        req2       = r2;
        commit_num = cn;
        flush      = fl;
        reset_n    = rn;
        e.ok    = hok;
        e.en1   = r1 & hok;
        e.en2   = r2 & hok;
        e.tag1  = 6'(m_ptr);
        e.tag2  = 6'((m_ptr + int'(r1)) % 64);
        e.ptr   = 6'(m_ptr);
        e.cyc   = m_cyc[0];
        e.cptr  = 6'(m_cptr);
        e.free  = 7'(m_free);
        e.stall = 32'(m_stall);
        q.push_back(e);

        if (!rn) begin
            m_ptr = 0; m_cyc = 0; m_cptr = 0; m_ccyc = 0; m_free = 64; m_stall = 0;
        end else begin
            granted = hok ? (int'(r1) + int'(r2)) : 0;
            if ((int'(r1) + int'(r2)) > 0 && !hok && !fl) m_stall++;
            np = m_ptr + granted;
            if (np >= 64) begin np -= 64; m_cyc ^= 1; end
            nc = m_cptr + int'(cn);
            if (nc >= 64) begin nc -= 64; m_ccyc ^= 1; end
            m_cptr = nc;
            if (fl) begin
                m_ptr = nc; m_cyc = m_ccyc; m_free = 64;
            end else begin
                m_ptr = np; m_free = m_free - granted + int'(cn);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0; req1 = 1'b0; req2 = 1'b0; commit_num = 2'd0; flush = 1'b0;
        m_ptr = 0; m_cyc = 0; m_cptr = 0; m_ccyc = 0; m_free = 64; m_stall = 0;

        step(1, 1, 0, 0, 1, 1);                        // tags 0,1
        step(0, 1, 0, 0, 1, 1);                        // slot 2 only gets tag 2
        for (int i = 0; i < 29; i++) step(1, 1, 0, 0, 1, 1);  // ptr 61, free 3
        step(1, 0, 2, 0, 1, 1);                        // ptr 62, free 4, cptr 2
        step(1, 0, 0, 0, 1, 1);                        // ptr 63, free 3
        step(1, 1, 0, 0, 1, 1);                        // tags 63,0, wrap flips cycle bit
        step(1, 1, 2, 0, 1, 0);                        // free 1: no partial grant; commit 2
        step(1, 1, 0, 0, 1, 1);                        // free 3 -> 1
        step(1, 0, 0, 0, 1, 1);                        // free 0
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1, 0);   // stalled
        step(0, 0, 0, 0, 1, 1);                        // no need -> ok even when empty
        step(0, 0, 1, 0, 1, 1);                        // commit frees one for next cycle
        step(1, 1, 0, 0, 1, 0);                        // 2 needed, 1 free
        step(1, 0, 0, 0, 1, 1);
        step(1, 0, 1, 1, 1, 0);                        // flush with commit: ptr=cptr=6
        step(1, 1, 0, 0, 1, 1);                        // tags 6,7 after flush
        step(0, 1, 0, 0, 1, 1);                        // tag2 = 8
        step(1, 1, 1, 1, 0, 0);                        // reset overrides everything
        step(0, 0, 0, 0, 1, 1);                        // reset state visible
        step(1, 1, 0, 0, 1, 1);                        // tags 0,1 again

        for (int i = 0; i < 4 && q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d expected=0 pending records", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
